// File: rtl/fpnew_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpnew_pkg                                                                  |
// | Shared FPU types used by the result collector.                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fpnew_pkg;

    // RISC-V exception flags: invalid, divide-by-zero, overflow, underflow, inexact.
    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

endpackage : fpnew_pkg
`default_nettype wire

// File: rtl/hub_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hub_sync_fifo                                                              |
// | Generic in-order FIFO with flush and occupancy count; head read from store.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hub_sync_fifo #(
    parameter int DataWidth = 32,
    parameter int Depth     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [DataWidth-1:0]   data_i,
    input  logic                   pop_i,
    output logic [DataWidth-1:0]   data_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int c_ptr_w = $clog2(Depth);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] mem_d [Depth];
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_cnt_w-1:0]   count_q, count_d;

    logic w_push;
    logic w_pop;

    assign full_o  = (count_q == c_cnt_w'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    // Depth is a power of two, so pointers wrap by natural overflow;
    // full vs. empty is resolved by the count, never by pointer equality.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
            end
            count_d = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : hub_sync_fifo
`default_nettype wire

// File: rtl/fpnew_result_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpnew_result_collector                                                     |
// | Buffers FPU result beats in order and accumulates sticky fflags.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fpnew_result_collector
    import fpnew_pkg::*;
#(
    parameter int Width    = 32,
    parameter int TagWidth = 1,
    parameter int Depth    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   fpu_valid_i,
    output logic                   fpu_ready_o,
    input  logic [Width-1:0]       fpu_result_i,
    input  status_t                fpu_status_i,
    input  logic [TagWidth-1:0]    fpu_tag_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [Width-1:0]       rsp_result_o,
    output status_t                rsp_status_o,
    output logic [TagWidth-1:0]    rsp_tag_o,
    output status_t                fflags_o,
    input  logic                   fflags_clr_i,
    output logic [$clog2(Depth):0] count_o
);

    typedef struct packed {
        logic [Width-1:0]    result;
        status_t             status;
        logic [TagWidth-1:0] tag;
    } payload_t;

    localparam int c_payload_w = $bits(payload_t);

    payload_t w_wr_payload;
    payload_t w_rd_payload;
    logic     w_full;
    logic     w_empty;
    logic     w_push;
    logic     w_pop;
    status_t  fflags_q, fflags_d;

    // Ready comes only from registered occupancy, never from rsp_ready_i.
    assign fpu_ready_o = !w_full;
    assign rsp_valid_o = !w_empty;
    assign w_push      = fpu_valid_i && fpu_ready_o;
    assign w_pop       = rsp_valid_o && rsp_ready_i;

    assign w_wr_payload = '{result: fpu_result_i, status: fpu_status_i, tag: fpu_tag_i};

    hub_sync_fifo #(
        .DataWidth (c_payload_w),
        .Depth     (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (w_push),
        .data_i  (w_wr_payload),
        .pop_i   (w_pop),
        .data_o  (w_rd_payload),
        .count_o (count_o),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign rsp_result_o = w_rd_payload.result;
    assign rsp_status_o = w_rd_payload.status;
    assign rsp_tag_o    = w_rd_payload.tag;

    // A beat accepted on a flush cycle is discarded but its flags still count.
    always_comb begin
        fflags_d = fflags_clr_i ? status_t'('0) : fflags_q;
        if (w_push) begin
            fflags_d = status_t'(fflags_d | fpu_status_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags_o = fflags_q;

endmodule : fpnew_result_collector
`default_nettype wire

// File: doc/fpnew_result_collector.md
Name: fpnew_result_collector

Overview:
- Downstream responder for the result side of fpnew_top: it drives out_ready and accepts result, status and tag beats.
- Buffers accepted results in an in-order FIFO and presents them to a consumer (core writeback or bench scoreboard) over valid/ready.
- Accumulates the RISC-V-style sticky exception flags (fflags) from every accepted status word, with a software clear.

Parameters:
- Width, 32, result width in bits; matches fpnew_top Features.Width.
- TagWidth, 1, width of the tag carried alongside each result.
- Depth, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  discard all buffered results, synchronous
- fpu_valid_i  in  1  result beat valid (fpnew_top out_valid_o)
- fpu_ready_o  out  1  collector can accept (drives fpnew_top out_ready_i)
- fpu_result_i  in  Width  result (fpnew_top result_o)
- fpu_status_i  in  5  fpnew_pkg::status_t {NV,DZ,OF,UF,NX}
- fpu_tag_i  in  TagWidth  tag (fpnew_top tag_o)
- rsp_valid_o  out  1  head entry valid to consumer
- rsp_ready_i  in  1  consumer accepts head
- rsp_result_o  out  Width  head result
- rsp_status_o  out  5  head status
- rsp_tag_o  out  TagWidth  head tag
- fflags_o  out  5  sticky OR of accepted status words
- fflags_clr_i  in  1  clear fflags_o
- count_o  out  $clog2(Depth)+1  current occupancy

Behaviour:
- Reset (rst_i high at a clock edge) sets FIFO empty, count_o=0, rsp_valid_o=0, fflags_o=0, and fpu_ready_o=1 from the following cycle.
  - rsp_result_o, rsp_status_o and rsp_tag_o are 0 after reset.
  - Reset mid-operation drops all entries; any beat presented on the reset cycle is lost.
- Push occurs when fpu_valid_i && fpu_ready_o.
- Pop occurs when rsp_valid_o && rsp_ready_i.
- fpu_ready_o = (count_o != Depth) and depends only on registered state: there is no combinational path from rsp_ready_i.
- rsp_valid_o = (count_o != 0). Head outputs come straight from storage at the read pointer; they are stable while rsp_valid_o && !rsp_ready_i.
- Latency is one cycle: a beat pushed at edge N is visible at the head after edge N. There is no same-cycle bypass when empty.
- Simultaneous push and pop:
  - When not empty: count is unchanged and both pointers advance.
  - When full: the push is impossible because fpu_ready_o=0; the pop proceeds.
  - When empty: only the push takes effect.
- Pointers wrap modulo Depth. Full and empty are distinguished by count_o, not by pointer equality.
- Each cycle, fflags_next = (fflags_clr_i ? 0 : fflags_o) | (push ? fpu_status_i : 0).
  - Clear and push in the same cycle leaves only the pushed status.
  - Flags are captured at push time, not at pop time.
- Flush:
  - Sets count_o=0 and resets both pointers on the next edge.
  - Any push or pop on the flush cycle has no effect on storage.
  - fpu_ready_o stays as computed, so a handshake on the flush cycle completes and its data is discarded.
  - The discarded beat's status IS still ORed into fflags_o, because flags are architectural. fflags_o is otherwise unaffected by flush.
- rst_i has priority over flush_i, and flush_i has priority over push/pop.
- There is no overflow or underflow error path; it is unreachable by construction. A bench assertion covers it.

Decomposition:
- Reuse fpnew_pkg::status_t for the status ports and the fflags register; no new package is needed.
- Storage and pointers go in one generic sub-module, hub_sync_fifo (parameters DataWidth, Depth; sync active-high reset; flush_i; count output).
  - Its payload is a packed struct {result, status, tag}.
  - fpnew_result_collector adds the fflags logic and the port mapping.

Test Plan:
- Reset then single beat: push result=0x40000000, status=0, tag=1 -> rsp_valid_o=1 one cycle later with identical head; fflags_o=0; count_o=1, returning to 0 after pop.
- Back-pressure fill: rsp_ready_i=0, push 5 beats with Depth=4 -> fpu_ready_o=0 after the 4th; the 5th is held at the source; count_o=4. Then pop the 4 in order (results 0x1..0x4), followed by 0x5.
- Full with simultaneous pop and push: at count=4 pop one -> fpu_ready_o=1 next cycle; push and pop together at count=3 keep count_o=3 and preserve ordering.
- Sticky flags: push status 5'b00001 (NX), then 5'b10000 (NV) -> fflags_o=5'b10001. Assert fflags_clr_i in the same cycle as a push of 5'b00100 (OF) -> fflags_o=5'b00100.
- Flush: 3 entries buffered, flush_i plus a push of status=DZ -> count_o=0 and rsp_valid_o=0 next cycle; fflags_o includes 5'b01000; the next pushed beat emerges first.
- Reset mid-stream: 2 entries buffered, rst_i for 1 cycle -> all outputs 0, fpu_ready_o=1 the next cycle, no stale beat is ever presented.
